// File: rtl/ofm_sched_pkg.sv
// Shared definitions for the OFM write scheduler: FSM encoding and beat geometry.
package ofm_sched_pkg;

  // Bytes per accepted output beat (512-bit stream); must be a power of two.
  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFER = 3'd2,
    ST_NEXT = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  // Width able to hold ceil(bytes / BEAT_BYTES) for a size_w-bit byte count.
  function automatic int unsigned beat_cnt_w(input int unsigned size_w);
    return size_w - BEAT_SHIFT + 1;
  endfunction

endpackage

// File: rtl/ofm_beat_tracker.sv
// Per-tile beat accounting: counts accepted beats, remembers the write-master
// completion pulse, flags tile completion and detects surplus beats.
module ofm_beat_tracker
  import ofm_sched_pkg::*;
#(
  parameter int unsigned SIZE_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [SIZE_W-1:0] i_tile_bytes,
  input  logic              i_clr,
  input  logic              i_in_xfer,
  input  logic              i_ovf_window,
  input  logic              i_beat_fire,
  input  logic              i_wmst_done,
  output logic              o_complete_c,
  output logic              o_overrun
);

  localparam int unsigned EXP_W = beat_cnt_w(SIZE_W);
  localparam int unsigned SUM_W = SIZE_W + 1;

  logic [EXP_W-1:0] r_expected;
  logic [EXP_W-1:0] r_beat_cnt;
  logic             r_done_seen;
  logic             r_overrun;

  logic [SUM_W-1:0] w_round_up;
  logic [EXP_W-1:0] w_cnt_nxt;
  logic             w_full;
  logic             w_beat_ok;
  logic             w_seen_nxt;
  logic             w_ovf_hit;

  // Extra carry bit so tile_bytes near 2^SIZE_W still rounds up correctly.
  assign w_round_up = SUM_W'(i_tile_bytes) + SUM_W'(BEAT_BYTES - 1);

  assign w_full     = (r_beat_cnt == r_expected);
  assign w_beat_ok  = i_in_xfer & i_beat_fire & ~w_full;
  assign w_cnt_nxt  = r_beat_cnt + EXP_W'(w_beat_ok);
  assign w_seen_nxt = r_done_seen | (i_in_xfer & i_wmst_done);
  assign w_ovf_hit  = i_beat_fire & ((i_in_xfer & w_full) | i_ovf_window);

  // Completion looks through this cycle's beat and done pulse.
  assign o_complete_c = i_in_xfer & (w_cnt_nxt == r_expected) & w_seen_nxt;
  assign o_overrun    = r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expected  <= '0;
      r_beat_cnt  <= '0;
      r_done_seen <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (i_load) begin
        r_expected <= EXP_W'(w_round_up >> BEAT_SHIFT);
      end
      if (i_load || i_clr) begin
        r_beat_cnt  <= '0;
        r_done_seen <= 1'b0;
      end else if (i_in_xfer) begin
        r_beat_cnt  <= w_cnt_nxt;
        r_done_seen <= w_seen_nxt;
      end
      if (i_load) begin
        r_overrun <= 1'b0;
      end else if (w_ovf_hit) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ofm_wr_scheduler.sv
// Issues one write-master transfer per OFM tile in order, advancing the
// destination address by a fixed stride once each tile has fully completed.
module ofm_wr_scheduler
  import ofm_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned SIZE_W = 32,
  parameter int unsigned TILE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [SIZE_W-1:0] tile_bytes,
  input  logic [ADDR_W-1:0] tile_stride,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              abort,
  input  logic              beat_fire,
  input  logic              wmst_done,
  output logic              wmst_req,
  output logic [ADDR_W-1:0] wmst_addr,
  output logic [63:0]       wmst_xfer_size,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic              beat_overrun
);

  state_e            r_state;
  logic              r_req;
  logic              r_done;
  logic              r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [SIZE_W-1:0] r_tile_bytes;
  logic [TILE_W-1:0] r_num_tiles;
  logic [TILE_W-1:0] r_tile_idx;

  logic              w_load;
  logic              w_complete;
  logic              w_in_xfer;
  logic              w_ovf_window;
  logic [TILE_W-1:0] w_idx_nxt;

  assign w_load       = (r_state == ST_IDLE) & start & ~abort;
  assign w_in_xfer    = (r_state == ST_XFER);
  assign w_ovf_window = (r_state == ST_IDLE) | (r_state == ST_REQ) | (r_state == ST_NEXT);
  assign w_idx_nxt    = r_tile_idx + TILE_W'(1);

  ofm_beat_tracker #(
    .SIZE_W (SIZE_W)
  ) u_beat_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_tile_bytes (tile_bytes),
    .i_clr        (r_state == ST_NEXT),
    .i_in_xfer    (w_in_xfer),
    .i_ovf_window (w_ovf_window),
    .i_beat_fire  (beat_fire),
    .i_wmst_done  (wmst_done),
    .o_complete_c (w_complete),
    .o_overrun    (beat_overrun)
  );

  // Layer sequencer; req/done/busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_req        <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_addr       <= '0;
      r_stride     <= '0;
      r_tile_bytes <= '0;
      r_num_tiles  <= '0;
      r_tile_idx   <= '0;
    end else begin
      r_req  <= 1'b0;
      r_done <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_addr       <= base_addr;
              r_stride     <= tile_stride;
              r_tile_bytes <= tile_bytes;
              r_num_tiles  <= num_tiles;
              r_tile_idx   <= '0;
              r_busy       <= 1'b1;
              if ((num_tiles == '0) || (tile_bytes == '0)) begin
                r_state <= ST_FIN;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_REQ;
                r_req   <= 1'b1;
              end
            end
          end
          ST_REQ: begin
            r_state <= ST_XFER;
          end
          ST_XFER: begin
            if (w_complete) begin
              r_state <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            // Stride is accumulated rather than multiplied; wraps mod 2^ADDR_W.
            r_tile_idx <= w_idx_nxt;
            r_addr     <= r_addr + r_stride;
            if (w_idx_nxt == r_num_tiles) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
            end
          end
          ST_FIN: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wmst_req       = r_req;
  assign done           = r_done;
  assign busy           = r_busy;
  assign wmst_addr      = r_addr;
  assign tile_idx       = r_tile_idx;
  assign wmst_xfer_size = 64'(r_tile_bytes);

endmodule

// File: tb/tb_ofm_wr_scheduler.sv
// Randomised bench for ofm_wr_scheduler: a timestamp-based layer model checks
// every output each cycle, plus literal checks on the directed scenarios.
module tb_ofm_wr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        beat_fire = 1'b0;
  logic        wmst_done = 1'b0;
  logic [63:0] base_addr = '0;
  logic [63:0] tile_stride = '0;
  logic [31:0] tile_bytes = '0;
  logic [15:0] num_tiles = '0;

  logic        wmst_req;
  logic [63:0] wmst_addr;
  logic [63:0] wmst_xfer_size;
  logic [15:0] tile_idx;
  logic        busy;
  logic        done;
  logic        beat_overrun;

  int checks = 0;
  int errors = 0;

  ofm_wr_scheduler #(
    .ADDR_W (64),
    .SIZE_W (32),
    .TILE_W (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .tile_bytes     (tile_bytes),
    .tile_stride    (tile_stride),
    .num_tiles      (num_tiles),
    .abort          (abort),
    .beat_fire      (beat_fire),
    .wmst_done      (wmst_done),
    .wmst_req       (wmst_req),
    .wmst_addr      (wmst_addr),
    .wmst_xfer_size (wmst_xfer_size),
    .tile_idx       (tile_idx),
    .busy           (busy),
    .done           (done),
    .beat_overrun   (beat_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (event timestamps per cycle) ----------------
  longint      t = 0;
  bit          m_active;
  bit          m_in_xfer;
  bit          m_dseen;
  bit          m_ovf;
  int          m_k;
  int          m_num;
  longint      m_beats;
  longint      m_exp;
  longint      m_req_at;
  longint      m_next_at;
  longint      m_fin_at;
  logic [63:0] m_base;
  logic [63:0] m_stride;
  logic [31:0] m_bytes;

  logic [63:0] req_log[$];
  int          done_cnt = 0;

  task automatic model_reset();
    m_active = 0; m_in_xfer = 0; m_dseen = 0; m_ovf = 0;
    m_k = 0; m_num = 0; m_beats = 0; m_exp = 0;
    m_req_at = -1; m_next_at = -1; m_fin_at = -1;
    m_base = '0; m_stride = '0; m_bytes = '0;
  endtask

  task automatic model_compare();
    chk("req", wmst_req, 64'(t == m_req_at));
    chk("done", done, 64'(t == m_fin_at));
    chk("busy", busy, 64'(m_active));
    chk("tile_idx", tile_idx, 64'(16'(m_k)));
    chk("addr", wmst_addr, m_base + 64'(m_k) * m_stride);
    chk("xfer_size", wmst_xfer_size, 64'(m_bytes));
    chk("overrun", beat_overrun, 64'(m_ovf));
  endtask

  task automatic model_step();
    bit ph_req, ph_next, ph_fin;
    ph_req  = (t == m_req_at);
    ph_next = (t == m_next_at);
    ph_fin  = (t == m_fin_at);
    if (!m_active) begin
      if (start && !abort) begin
        m_base = base_addr; m_stride = tile_stride; m_bytes = tile_bytes; m_num = int'(num_tiles);
        m_k = 0; m_ovf = 0; m_beats = 0; m_dseen = 0; m_active = 1;
        m_exp = (longint'(tile_bytes) + 63) / 64;
        if (num_tiles == 0 || tile_bytes == 0) m_fin_at = t + 1;
        else m_req_at = t + 1;
      end else if (beat_fire) begin
        m_ovf = 1;
      end
    end else begin
      if (beat_fire && (ph_req || ph_next)) m_ovf = 1;
      if (m_in_xfer && beat_fire && m_beats == m_exp) m_ovf = 1;
      if (abort) begin
        m_active = 0; m_in_xfer = 0;
        m_req_at = -1; m_next_at = -1; m_fin_at = -1;
      end else if (ph_req) begin
        m_in_xfer = 1;
      end else if (m_in_xfer) begin
        if (beat_fire && m_beats < m_exp) m_beats++;
        if (wmst_done) m_dseen = 1;
        if (m_beats == m_exp && m_dseen) begin
          m_in_xfer = 0;
          m_next_at = t + 1;
        end
      end else if (ph_next) begin
        m_k++;
        m_beats = 0; m_dseen = 0;
        if (m_k == m_num) m_fin_at = t + 1;
        else m_req_at = t + 1;
      end else if (ph_fin) begin
        m_active = 0;
      end
    end
  endtask

  // Single compare process: checks this cycle's outputs, then advances the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_req", wmst_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", wmst_addr, 0);
      chk("rst_idx", tile_idx, 0);
      chk("rst_ovf", beat_overrun, 0);
    end else begin
      if (wmst_req) req_log.push_back(wmst_addr);
      if (done) done_cnt++;
      model_compare();
      model_step();
    end
    t++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [63:0] b, input logic [31:0] by,
                             input logic [63:0] s, input logic [15:0] n);
    base_addr = b; tile_bytes = by; tile_stride = s; num_tiles = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!wmst_req && n < 50) begin
      tick();
      n++;
    end
    ok = wmst_req;
    if (!ok) chk("req_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk("done_timeout", done, 1);
    tick();
  endtask

  // Called in the REQ cycle; emulates the stream and write master for one tile.
  task automatic serve_tile(input int nb, input bit extra);
    int beats_left = nb + (extra ? 1 : 0);
    bit done_pending = 1;
    bit do_beat, do_done;
    tick();
    while (beats_left > 0 || done_pending) begin
      repeat ($urandom_range(0, 2)) tick();
      do_beat = (beats_left > 0);
      do_done = 0;
      if (done_pending) begin
        if (extra) do_done = (beats_left <= 1);
        else if (beats_left == 0) do_done = 1;
        else do_done = ($urandom_range(0, nb) == 0);
      end
      if (do_done && !extra && beats_left > 0 && $urandom_range(0, 1) == 1) do_beat = 0;
      beat_fire = do_beat;
      wmst_done = do_done;
      tick();
      beat_fire = 1'b0;
      wmst_done = 1'b0;
      if (do_beat) beats_left--;
      if (do_done) done_pending = 0;
    end
  endtask

  task automatic run_layer(input logic [63:0] b, input logic [31:0] by,
                           input logic [63:0] s, input logic [15:0] n, input int extra_tile);
    bit ok;
    int nb;
    nb = int'((longint'(by) + 63) / 64);
    start_layer(b, by, s, n);
    if (n != 0 && by != 0) begin
      for (int k = 0; k < int'(n); k++) begin
        wait_req(ok);
        if (!ok) return;
        serve_tile(nb, k == extra_tile);
      end
    end
    wait_done();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit ok;
    int d0, r0, lat;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Three 256-byte tiles at stride 0x400.
    req_log.delete();
    run_layer(64'h1000, 32'd256, 64'h400, 16'd3, -1);
    chk("t1_req_count", req_log.size(), 3);
    if (req_log.size() == 3) begin
      chk("t1_addr0", req_log[0], 64'h1000);
      chk("t1_addr1", req_log[1], 64'h1400);
      chk("t1_addr2", req_log[2], 64'h1800);
    end
    chk("t1_size", wmst_xfer_size, 64'd256);
    chk("t1_idle", busy, 0);

    // 100-byte tile: done arrives between the two beats.
    d0 = done_cnt;
    start_layer(64'h3000, 32'd100, 64'h40, 16'd1);
    tick();
    beat_fire = 1'b1; tick(); beat_fire = 1'b0;
    wmst_done = 1'b1; tick(); wmst_done = 1'b0;
    tick(); tick();
    chk("t2_still_busy", busy, 1);
    chk("t2_no_early_done", done_cnt - d0, 0);
    beat_fire = 1'b1; tick(); beat_fire = 1'b0;
    wait_done();
    chk("t2_one_done", done_cnt - d0, 1);
    chk("t2_no_overrun", beat_overrun, 0);

    // Zero tiles: no request, done right away.
    req_log.delete();
    start_layer(64'h5000, 32'd256, 64'h400, 16'd0);
    lat = 1;
    while (!done && lat < 10) begin tick(); lat++; end
    chk("t3_done_seen", done, 1);
    chk("t3_done_lat", 64'(lat <= 2), 1);
    tick();
    chk("t3_no_req", req_log.size(), 0);

    // Fifth beat on a 256-byte tile sets a sticky overrun.
    run_layer(64'h8000, 32'd256, 64'h100, 16'd2, 0);
    chk("t4_ovf_sticky", beat_overrun, 1);
    start_layer(64'h9000, 32'd64, 64'h40, 16'd1);
    chk("t4_ovf_cleared", beat_overrun, 0);
    serve_tile(1, 0);
    wait_done();

    // Abort during tile 1, then a restart from base.
    start_layer(64'h2000, 32'd128, 64'h100, 16'd3);
    wait_req(ok);
    if (ok) serve_tile(2, 0);
    wait_req(ok);
    tick();
    beat_fire = 1'b1; tick(); beat_fire = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_abort_idle", busy, 0);
    d0 = done_cnt;
    r0 = req_log.size();
    repeat (5) tick();
    chk("t5_no_req", req_log.size() - r0, 0);
    chk("t5_no_done", done_cnt - d0, 0);
    req_log.delete();
    run_layer(64'h2000, 32'd128, 64'h100, 16'd3, -1);
    chk("t5_restart_count", req_log.size(), 3);
    if (req_log.size() > 0) chk("t5_restart_addr", req_log[0], 64'h2000);

    // Address wrap, with a start pulse while busy that must be ignored.
    req_log.delete();
    start_layer(64'hFFFF_FFFF_FFFF_FC00, 32'd64, 64'h400, 16'd2);
    tick();
    base_addr = 64'h5555_0000;
    start = 1'b1; tick(); start = 1'b0;
    beat_fire = 1'b1; wmst_done = 1'b1; tick(); beat_fire = 1'b0; wmst_done = 1'b0;
    wait_req(ok);
    if (ok) serve_tile(1, 0);
    wait_done();
    chk("t6_req_count", req_log.size(), 2);
    if (req_log.size() == 2) begin
      chk("t6_addr0", req_log[0], 64'hFFFF_FFFF_FFFF_FC00);
      chk("t6_addr1_wrap", req_log[1], 64'h0);
    end

    // Reset in the middle of a layer.
    start_layer(64'h7000, 32'd256, 64'h80, 16'd2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_addr", wmst_addr, 0);
    chk("t7_rst_size", wmst_xfer_size, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Randomised layers with stray beats/done pulses between them.
    for (int l = 0; l < 40; l++) begin
      logic [63:0] b, s;
      logic [31:0] by;
      logic [15:0] n;
      int xt;
      b  = {$urandom(), $urandom()};
      s  = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 4096));
      by = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 400));
      n  = 16'($urandom_range(0, 4));
      xt = (n != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, int'(n) - 1) : -1;
      run_layer(b, by, s, n, xt);
      repeat ($urandom_range(0, 3)) begin
        beat_fire = ($urandom_range(0, 7) == 0);
        wmst_done = ($urandom_range(0, 7) == 0);
        tick();
        beat_fire = 1'b0;
        wmst_done = 1'b0;
      end
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
